// File: rtl/bsg_core_arbiter.sv
// rtl/bsg_core_arbiter.sv - round-robin arbiter sharing one bsg_control_core among N requesters
// Optional watchdog enabled by defining BSG_CORE_ARB_WDOG_EN.
module bsg_core_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned WDOG_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         step,
  input  logic [1:0]           core_state,
  output logic                 core_in,
  output logic                 core_reset,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 wdog_err
);

  localparam int unsigned IW       = $clog2(N);
  localparam logic [7:0]  HOLD_MAX = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    GRANT = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e         state_q;
  state_e         state_d;
  logic [IW-1:0]  rr_q;
  logic [IW-1:0]  win_id;
  logic [IW-1:0]  cand;
  logic           win_found;
  logic [N-1:0]   own_mask;
  logic           other_req;
  logic [7:0]     hold_q;
  logic [7:0]     hold_now;
  logic           preempt;
  logic           wdog_fire;
  logic [N-1:0]   gnt_d;
  logic           core_in_d;
  logic           core_reset_d;
  logic           busy_d;

  // Scan cyclically starting just after the last owner.
  always_comb begin
    win_found = 1'b0;
    win_id    = rr_q;
    cand      = rr_q;
    for (int k = 1; k <= int'(N); k++) begin
      cand = IW'((int'(rr_q) + k) % int'(N));
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign own_mask  = {{(N-1){1'b0}}, 1'b1} << gnt_id;
  assign other_req = |(req & ~own_mask);

  // hold_now counts GRANT cycles including the current one.
  assign hold_now = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + 8'd1;
  assign preempt  = (hold_now == HOLD_MAX) && other_req;

`ifdef BSG_CORE_ARB_WDOG_EN
  localparam logic [7:0] WDOG_MAX = 8'(WDOG_CYCLES);
  logic [7:0] wdog_q;

  assign wdog_fire = (state_q == GRANT) && (core_state != 2'b11) &&
                     (wdog_q >= WDOG_MAX - 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q   <= 8'd0;
      wdog_err <= 1'b0;
    end else begin
      if (state_q == SETUP) begin
        wdog_q <= 8'd0;
      end else if (state_q == GRANT) begin
        wdog_q <= (core_state == 2'b11) ? 8'd0 : wdog_q + 8'd1;
      end
      if (wdog_fire) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = ^{core_state, 8'(WDOG_CYCLES)};
  assign wdog_fire   = 1'b0;
  assign wdog_err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = SETUP;
      SETUP:   state_d = GRANT;
      GRANT:   if (!req[gnt_id] || preempt || wdog_fire) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registers line up with the FSM.
  always_comb begin
    gnt_d        = '0;
    core_in_d    = 1'b0;
    core_reset_d = 1'b0;
    busy_d       = (state_d != IDLE);
    case (state_d)
      SETUP, DRAIN: core_reset_d = 1'b1;
      GRANT: begin
        gnt_d     = own_mask;
        core_in_d = step[gnt_id];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q       <= IW'(N - 1);
      gnt_id     <= '0;
      hold_q     <= 8'd0;
      gnt        <= '0;
      core_in    <= 1'b0;
      core_reset <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (state_q == IDLE && win_found) begin
        gnt_id <= win_id;
        rr_q   <= win_id;
      end
      if (state_q == SETUP) begin
        hold_q <= 8'd0;
      end else if (state_q == GRANT) begin
        hold_q <= hold_now;
      end
      gnt        <= gnt_d;
      core_in    <= core_in_d;
      core_reset <= core_reset_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_bsg_core_arbiter.sv
// tb/tb_bsg_core_arbiter.sv - directed self-checking bench for bsg_core_arbiter
module tb_bsg_core_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] step;
  logic [1:0] core_state;
  logic       core_in;
  logic       core_reset;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       wdog_err;

  int n_cmp;
  int n_bad;

  bsg_core_arbiter #(.N(4), .MAX_HOLD(8), .WDOG_CYCLES(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .step       (step),
    .core_state (core_state),
    .core_in    (core_in),
    .core_reset (core_reset),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .busy       (busy),
    .wdog_err   (wdog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // DRAIN, IDLE, SETUP handover; leaves the bench in the first GRANT cycle.
  task automatic gap(input int next_id);
    chk("drain_gnt", gnt, 0);
    chk("drain_core_reset", core_reset, 1);
    chk("drain_busy", busy, 1);
    tick();
    chk("idle_gnt", gnt, 0);
    chk("idle_core_reset", core_reset, 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("setup_gnt", gnt, 0);
    chk("setup_core_reset", core_reset, 1);
    chk("setup_busy", busy, 1);
    chk("setup_gnt_id", gnt_id, 32'(next_id));
    tick();
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    req        = 4'b1111;
    step       = 4'b1010;
    core_state = 2'b01;
    repeat (2) tick();

    chk("rst_gnt", gnt, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_wdog_err", wdog_err, 0);

    reset_n = 1'b1;
    tick();
    chk("post_rst_setup_busy", busy, 1);
    chk("post_rst_setup_gnt", gnt, 0);
    chk("post_rst_setup_core_reset", core_reset, 1);
    tick();

    // Round robin 0,1,2,3 with 8-cycle grants, then wrap to 0.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8; k++) begin
        chk("rr_gnt", gnt, 32'(1) << r);
        chk("rr_gnt_id", gnt_id, 32'(r));
        chk("rr_core_in", core_in, 32'(step[r]));
        chk("rr_core_reset", core_reset, 0);
        tick();
      end
      gap((r + 1) % 4);
    end
    chk("rr_wrap_gnt", gnt, 4'b0001);

    // Requester 0 leaves; 1 wins, releases after 3 cycles while 3 waits.
    req = 4'b1010;
    tick();
    gap(1);
    chk("rel_gnt_c1", gnt, 4'b0010);
    tick();
    chk("rel_gnt_c2", gnt, 4'b0010);
    tick();
    chk("rel_gnt_c3", gnt, 4'b0010);
    req = 4'b1000;
    tick();
    gap(3);
    chk("rel_next_gnt", gnt, 4'b1000);
    chk("rel_next_gnt_id", gnt_id, 3);

    // Lone requester 2 keeps the grant indefinitely.
    req = 4'b0000;
    tick();
    chk("empty_drain_gnt", gnt, 0);
    chk("empty_drain_core_reset", core_reset, 1);
    tick();
    tick();
    chk("empty_idle_busy", busy, 0);
    chk("empty_idle_core_reset", core_reset, 0);
    req  = 4'b0100;
    step = 4'b1111;
    tick();
    chk("single_setup_gnt_id", gnt_id, 2);
    tick();
    for (int k = 0; k < 50; k++) begin
      chk("single_gnt", gnt, 4'b0100);
      chk("single_core_in", core_in, 1);
      core_state = (k % 3 == 0) ? 2'b01 : ((k % 3 == 1) ? 2'b10 : 2'b11);
      tick();
    end

    // Asynchronous reset during requester 2's grant.
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_gnt_id", gnt_id, 0);
    core_state = 2'b10;
    step       = 4'b0000;
    req        = 4'b0110;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    chk("midrst_setup_gnt_id", gnt_id, 1);
    chk("midrst_setup_busy", busy, 1);
    tick();
    chk("midrst_first_gnt", gnt, 4'b0010);
    req = 4'b0010;

    // core_state parked at S1: watchdog limit is 32 GRANT cycles.
    for (int k = 0; k < 32; k++) begin
      chk("wdog_gnt_held", gnt, 4'b0010);
      chk("wdog_err_low", wdog_err, 0);
      tick();
    end
`ifdef BSG_CORE_ARB_WDOG_EN
    chk("wdog_drain_gnt", gnt, 0);
    chk("wdog_drain_core_reset", core_reset, 1);
    chk("wdog_err_set", wdog_err, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("wdog_err_sticky", wdog_err, 1);
    end
`else
    for (int k = 0; k < 10; k++) begin
      chk("nowdog_gnt", gnt, 4'b0010);
      chk("nowdog_err", wdog_err, 0);
      tick();
    end
`endif
    reset_n = 1'b0;
    tick();
    chk("wdog_err_cleared", wdog_err, 0);

    // req dropped during SETUP: one GRANT cycle, then DRAIN.
    req     = 4'b0001;
    reset_n = 1'b1;
    tick();
    chk("short_setup_busy", busy, 1);
    req = 4'b0000;
    tick();
    chk("short_gnt", gnt, 4'b0001);
    tick();
    chk("short_drain_gnt", gnt, 0);
    chk("short_drain_core_reset", core_reset, 1);
    tick();
    chk("short_idle_busy", busy, 0);
    chk("short_idle_gnt", gnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
